// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and unified-memory handshake signals around mem_arbiter.
// slave = the arbiter side, master = pipeline/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              err;
  logic              stall_F;
  logic              stall_M;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, err, stall_F, stall_M,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, err, stall_F, stall_M,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access, with ack timeout.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise data has fixed priority.
//
// state  | meaning
// IDLE   | no access in flight; sample requests and grant
// BUSY_I | fetch access on the memory port, waiting for ack/timeout
// BUSY_D | data access on the memory port, waiting for ack/timeout
// RESP   | one-cycle ready pulse to the served requester
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              serve_d_q, serve_d_d;
  logic              pick_d;
  logic              in_resp;

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;
  assign pick_d = bus.d_req & (~bus.if_req | ~last_d_q);
`else
  assign pick_d = bus.d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      serve_d_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      serve_d_q   <= serve_d_d;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    serve_d_d   = serve_d_q;
`ifdef MEM_ARB_RR_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_d     = pick_d ? BUSY_D : BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_d ? bus.d_we : 1'b0;
          mem_addr_d  = pick_d ? bus.d_addr : bus.if_addr;
          mem_wdata_d = pick_d ? bus.d_wdata : '0;
          // counter holds the index of the current BUSY cycle, starting at 1
          cnt_d       = CNT_W'(1);
          serve_d_d   = pick_d;
`ifdef MEM_ARB_RR_EN
          last_d_d    = pick_d;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          rdata_d   = mem_we_q ? '0 : bus.mem_rdata;
          err_d     = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_resp       = (state_q == RESP);
  assign bus.if_ready  = in_resp & ~serve_d_q;
  assign bus.d_ready   = in_resp & serve_d_q;
  assign bus.if_rdata  = bus.if_ready ? rdata_q : '0;
  assign bus.d_rdata   = bus.d_ready ? rdata_q : '0;
  assign bus.err       = in_resp & err_q;
  assign bus.stall_F   = bus.if_req & ~bus.if_ready;
  assign bus.stall_M   = bus.d_req & ~bus.d_ready;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus reset,
// stray-ack and contention sequences. Built with TIMEOUT=8.
module tb_mem_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;       // BUSY cycles without ack before the ack cycle
    logic [31:0] mrdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_busy;  // BUSY cycles until the access ends
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  lat;
    int  b;
    bit  got;
    logic [31:0] addr0;
    @(negedge clk);
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    lat = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_req) break;
    end
    check($sformatf("v%0d grant_latency", idx), 64'(lat), 64'(1));
    check($sformatf("v%0d mem_we", idx), 64'(bus.mem_we), 64'(v.is_d & v.we));
    check($sformatf("v%0d mem_addr", idx), 64'(bus.mem_addr), 64'(v.addr));
    if (v.is_d) check($sformatf("v%0d mem_wdata", idx), 64'(bus.mem_wdata), 64'(v.wdata));
    addr0 = bus.mem_addr;
    b = 1;
    bus.mem_rdata = v.mrdata;
    bus.mem_ack = (v.dly == 0);
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.if_ready || bus.d_ready) begin got = 1; break; end
      check($sformatf("v%0d stall_busy", idx),
            64'(v.is_d ? bus.stall_M : bus.stall_F), 64'(1));
      check($sformatf("v%0d addr_held", idx), 64'(bus.mem_addr), 64'(addr0));
      b++;
      bus.mem_ack = (b == v.dly + 1);
    end
    bus.mem_ack = 1'b0;
    check($sformatf("v%0d ready_seen", idx), 64'(got), 64'(1));
    check($sformatf("v%0d busy_cycles", idx), 64'(b), 64'(v.exp_busy));
    check($sformatf("v%0d d_ready", idx), 64'(bus.d_ready), 64'(v.is_d));
    check($sformatf("v%0d if_ready", idx), 64'(bus.if_ready), 64'(!v.is_d));
    check($sformatf("v%0d rdata", idx),
          64'(v.is_d ? bus.d_rdata : bus.if_rdata), 64'(v.exp_rdata));
    check($sformatf("v%0d other_rdata", idx),
          64'(v.is_d ? bus.if_rdata : bus.d_rdata), 64'(0));
    check($sformatf("v%0d err", idx), 64'(bus.err), 64'(v.exp_err));
    check($sformatf("v%0d mem_req_resp", idx), 64'(bus.mem_req), 64'(0));
    check($sformatf("v%0d stall_ready", idx),
          64'(v.is_d ? bus.stall_M : bus.stall_F), 64'(0));
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d idle_after", idx),
          64'({bus.if_ready, bus.d_ready, bus.err, bus.mem_req}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_is_d[4];
    int   n;
    int   cyc;
    int   last_cyc;

    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        2,   32'h20100005, 32'h20100005, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b1, 32'h10,  32'hDEADBEEF, 1,   32'h55AA55AA, 32'h0,        1'b0, 2};
    vecs[2] = '{1'b1, 1'b0, 32'h84,  32'h0,        0,   32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1};
    vecs[3] = '{1'b0, 1'b0, 32'h44,  32'h0,        5,   32'h8C090000, 32'h8C090000, 1'b0, 6};
    vecs[4] = '{1'b1, 1'b0, 32'h90,  32'h0,        7,   32'h0BADC0DE, 32'h0BADC0DE, 1'b0, 8};
    vecs[5] = '{1'b1, 1'b0, 32'hA0,  32'h0,        255, 32'hFFFFFFFF, 32'h0,        1'b1, 8};
    vecs[6] = '{1'b0, 1'b0, 32'h48,  32'h0,        255, 32'h12345678, 32'h0,        1'b1, 8};
    vecs[7] = '{1'b1, 1'b1, 32'hFC,  32'h01020304, 3,   32'h77777777, 32'h0,        1'b0, 4};

    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    #1;
    check("reset_outputs",
          64'({bus.mem_req, bus.mem_we, bus.if_ready, bus.d_ready, bus.err}), 64'(0));
    check("reset_mem_addr", 64'(bus.mem_addr), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // stray acks in IDLE must be ignored
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_ack_ignored",
            64'({bus.if_ready, bus.d_ready, bus.err, bus.mem_req}), 64'(0));
    end
    bus.mem_ack = 1'b0;

    // reset in the middle of an access abandons it
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300; bus.d_wdata = 32'h11112222;
    repeat (3) @(negedge clk);
    check("pre_reset_mem_req", 64'(bus.mem_req), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrun_reset_regs",
          64'({bus.mem_req, bus.mem_we, bus.if_ready, bus.d_ready, bus.err}), 64'(0));
    check("midrun_reset_addr", 64'(bus.mem_addr), 64'(0));
    check("midrun_reset_wdata", 64'(bus.mem_wdata), 64'(0));
    bus.d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_idle",
            64'({bus.if_ready, bus.d_ready, bus.err, bus.mem_req}), 64'(0));
    end

    // contention: both requests held for four grants, memory acks immediately
`ifdef MEM_ARB_RR_EN
    exp_is_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_is_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    n = 0; cyc = 0; last_cyc = 0;
    for (int c = 0; c < 60; c++) begin
      if (n >= 4) break;
      @(negedge clk);
      cyc++;
      if (bus.if_ready && bus.d_ready) check("ready_exclusive", 64'(1), 64'(0));
      if (bus.if_ready || bus.d_ready) begin
        check($sformatf("contention_grant%0d", n), 64'(bus.d_ready), 64'(exp_is_d[n]));
        check($sformatf("contention_rdata%0d", n),
              64'(bus.d_ready ? bus.d_rdata : bus.if_rdata), 64'(32'h1000 + cyc - 1));
        if (n > 0) check($sformatf("contention_spacing%0d", n), 64'(cyc - last_cyc), 64'(3));
        last_cyc = cyc;
        n++;
      end
      bus.mem_ack = bus.mem_req;
      bus.mem_rdata = 32'h1000 + cyc;
    end
    check("contention_grants", 64'(n), 64'(4));
    bus.mem_ack = 1'b0;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
